// File: rtl/serial_rx_pkg.sv
// Shared constants, state encoding and helpers for the 8b/9b serial receiver.
package serial_rx_pkg;

    localparam int DATA_GROUPS  = 8;
    localparam int FRAME_GROUPS = 10;
    localparam int GROUP_BITS   = 9;
    localparam int GAP_TX       = 24;

    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        DONE
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_rx_crc_guts.sv
// Bit-serial CRC-16 shared by the link transmitter and receiver.
module crc_guts
    import serial_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic gate,
    input  logic b_in,
    output logic b_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    // Feeding back b_out drains the register MSB-first, so b_out is the CRC stream.
    always_comb begin
        crc_d = crc_q;
        fb    = b_in ^ crc_q[15];
        if (clear) begin
            crc_d = '0;
        end else if (gate) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign b_out = crc_q[15];

endmodule

// File: rtl/serial_rx.sv
// Receive-side decoder for the 8b/9b framed serial link: 64-bit words
// protected by a 16-bit serial CRC.
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int GAP_MIN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        bit_in,
    output logic [63:0] d,
    output logic        strobe,
    output logic        crc_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] BIT_LAST  = 4'(GROUP_BITS - 1);
    localparam logic [3:0] BYTE_LAST = 4'(FRAME_GROUPS - 1);
    localparam logic [3:0] BYTE_DATA = 4'(DATA_GROUPS);
    localparam logic [4:0] GAP       = 5'(GAP_MIN);

    state_t      state_q, state_d;
    logic        sync1_q, s_q;
    logic [4:0]  zero_run_q, zero_run_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [63:0] sr_q, sr_d;
    logic        crc_bad_q, crc_bad_d;
    logic [63:0] d_q, d_d;
    logic        strobe_q, strobe_d;
    logic        crc_ok_q, crc_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic crc_clear;
    logic crc_gate;
    logic crc_b_out;

    assign crc_gate = tick && (state_q == DATA) && (bit_cnt_q != BIT_LAST);

    crc_guts u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (crc_clear),
        .gate  (crc_gate),
        .b_in  (s_q),
        .b_out (crc_b_out)
    );

    always_comb begin
        state_d     = state_q;
        zero_run_d  = zero_run_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        sr_d        = sr_q;
        crc_bad_d   = crc_bad_q;
        d_d         = d_q;
        err_cnt_d   = err_cnt_q;
        strobe_d    = 1'b0;
        crc_ok_d    = 1'b0;
        frame_err_d = 1'b0;
        crc_clear   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (tick) begin
                    if (!s_q) begin
                        if (zero_run_q != GAP) zero_run_d = zero_run_q + 5'd1;
                    end else if (zero_run_q == GAP) begin
                        crc_clear  = 1'b1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        crc_bad_d  = 1'b0;
                        state_d    = DATA;
                    end else begin
                        zero_run_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        if (byte_cnt_q < BYTE_DATA) begin
                            sr_d = {s_q, sr_q[63:1]};
                        end else if (s_q != crc_b_out) begin
                            crc_bad_d = 1'b1;
                        end
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (!s_q) begin
                        frame_err_d = 1'b1;
                        err_cnt_d   = sat_inc8(err_cnt_q);
                        zero_run_d  = 5'd1;
                        state_d     = HUNT;
                    end else begin
                        bit_cnt_d = '0;
                        if (byte_cnt_q == BYTE_LAST) begin
                            // Strobe is registered so it is high during DONE.
                            strobe_d = 1'b1;
                            crc_ok_d = ~crc_bad_q;
                            if (!crc_bad_q) d_d = sr_q;
                            else err_cnt_d = sat_inc8(err_cnt_q);
                            state_d = DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                zero_run_d = '0;
                state_d    = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            sync1_q     <= 1'b0;
            s_q         <= 1'b0;
            zero_run_q  <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            sr_q        <= '0;
            crc_bad_q   <= 1'b0;
            d_q         <= '0;
            strobe_q    <= 1'b0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bit_in;
            s_q         <= sync1_q;
            zero_run_q  <= zero_run_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sr_q        <= sr_d;
            crc_bad_q   <= crc_bad_d;
            d_q         <= d_d;
            strobe_q    <= strobe_d;
            crc_ok_q    <= crc_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign d         = d_q;
    assign strobe    = strobe_q;
    assign crc_ok    = crc_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: a line driver serialises frames while a
// monitor pops expected strobe/frame_err events and compares them.
module tb_serial_rx;
    import serial_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        bit_in = 1'b0;
    logic [63:0] d;
    logic        strobe;
    logic        crc_ok;
    logic        frame_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    serial_rx #(.GAP_MIN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .bit_in    (bit_in),
        .d         (d),
        .strobe    (strobe),
        .crc_ok    (crc_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        bit          is_strobe;
        bit          ok;
        logic [63:0] d;
        logic [7:0]  err;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_d = '0;
    logic [7:0]  exp_err = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [63:0] data);
        logic [15:0] c = '0;
        for (int i = 0; i < 64; i++) begin
            logic fb = data[i] ^ c[15];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // One bit period is two clocks with a single tick pulse.
    task automatic send_bit(input logic b);
        bit_in = b;
        tick = 1'b0;
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0);
        tick = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] data, input int flip,
                              input int bad_stuff, input int abort_at);
        logic [90:0] bits;
        logic [63:0] line;
        logic [15:0] c;
        line = data;
        if (flip >= 0) line[flip] = ~line[flip];
        c = crc16(data);
        bits = '0;
        bits[0] = 1'b1;
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 8; j++) begin
                if (g < 8) bits[1 + g*9 + j] = line[g*8 + j];
                else bits[1 + g*9 + j] = c[15 - (g-8)*8 - j];
            end
            bits[1 + g*9 + 8] = (g != bad_stuff);
        end
        for (int i = 0; i < 91; i++) begin
            if (i == abort_at) begin
                bit_in = 1'b0;
                tick = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            send_bit(bits[i]);
        end
    endtask

    task automatic exp_frame(input bit ok, input logic [63:0] data);
        if (ok) exp_d = data;
        else exp_err = sat_inc8(exp_err);
        q.push_back('{1'b1, ok, exp_d, exp_err});
    endtask

    task automatic exp_ferr();
        exp_err = sat_inc8(exp_err);
        q.push_back('{1'b0, 1'b0, exp_d, exp_err});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_d"}, d, 64'h0);
        chk({tag, "_strobe"}, {63'h0, strobe}, 64'h0);
        chk({tag, "_crc_ok"}, {63'h0, crc_ok}, 64'h0);
        chk({tag, "_frame_err"}, {63'h0, frame_err}, 64'h0);
        chk({tag, "_err_cnt"}, {56'h0, err_cnt}, 64'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (strobe || frame_err) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: strobe=%0b frame_err=%0b want none",
                             strobe, frame_err);
                end else begin
                    e = q.pop_front();
                    chk("strobe", {63'h0, strobe}, {63'h0, e.is_strobe});
                    chk("frame_err", {63'h0, frame_err}, {63'h0, !e.is_strobe});
                    chk("crc_ok", {63'h0, crc_ok}, {63'h0, e.ok});
                    chk("d", d, e.d);
                    chk("err_cnt", {56'h0, err_cnt}, {56'h0, e.err});
                end
            end
            if (!strobe && crc_ok) begin
                tests++;
                fails++;
                $display("FAIL crc_ok_idle: got 1 want 0");
            end
        end
    end

    localparam logic [63:0] A = 64'h0123456789ABCDEF;
    localparam logic [63:0] B = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] C = 64'h55AA33CC0F0FF0F0;
    localparam logic [63:0] E = 64'h13579BDF02468ACE;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        idle(GAP_TX);
        exp_frame(1'b1, A);
        send_frame(A, -1, -1, -1);
        idle(GAP_TX);

        exp_frame(1'b0, A);
        send_frame(A, 37, -1, -1);
        idle(GAP_TX);

        exp_ferr();
        send_frame(B, -1, 3, -1);
        idle(GAP_TX);
        exp_frame(1'b1, B);
        send_frame(B, -1, -1, -1);

        idle(12);
        send_frame(C, -1, -1, -1);
        idle(GAP_TX);
        exp_frame(1'b1, C);
        send_frame(C, -1, -1, -1);
        idle(GAP_TX);

        exp_frame(1'b1, 64'h0);
        send_frame(64'h0, -1, -1, -1);
        idle(GAP_TX);
        exp_frame(1'b1, 64'hFFFFFFFFFFFFFFFF);
        send_frame(64'hFFFFFFFFFFFFFFFF, -1, -1, -1);
        idle(GAP_TX);
        exp_frame(1'b1, 64'h8000000000000001);
        send_frame(64'h8000000000000001, -1, -1, -1);
        idle(GAP_TX);

        send_frame(A, -1, -1, 1 + 5*9 + 4);
        @(negedge clk);
        chk_reset_state("midrst");
        exp_d = '0;
        exp_err = '0;
        #1;
        idle(GAP_TX);
        exp_frame(1'b1, E);
        send_frame(E, -1, -1, -1);
        idle(GAP_TX);

        repeat (4) @(posedge clk);
        chk("queue_empty", 64'(q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
